// File: rtl/next_pc_predictor.sv
// Fetch-side next-PC generator: direct-mapped BTB with 2-bit counters plus mispredict redirect.
// Optional macro PRED_STATS_EN adds branch / mispredict event counters.
module next_pc_predictor #(
   parameter int IDX_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_current,
   output logic [31:0] next_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   output logic        flush
`ifdef PRED_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
`endif
);

   localparam int TAG_BITS = 30 - IDX_BITS;
   localparam int ENTRIES  = 1 << IDX_BITS;

   logic                r_valid  [ENTRIES];
   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [31:0]         r_target [ENTRIES];
   logic [1:0]          r_ctr    [ENTRIES];

   logic [IDX_BITS-1:0] w_idx;
   logic [TAG_BITS-1:0] w_tag;
   logic [IDX_BITS-1:0] w_upd_idx;
   logic [TAG_BITS-1:0] w_upd_tag;
   logic [31:0]         w_pc_plus4;
   logic [31:0]         w_upd_pc_plus4;
   logic                w_hit;
   logic                w_upd_hit;
   logic [1:0]          w_upd_ctr;
   logic [1:0]          w_ctr_next;
   logic                w_mispredict;
   logic [3:0]          w_unused_low_bits;

   assign w_idx             = pc_current[IDX_BITS+1:2];
   assign w_tag             = pc_current[31:IDX_BITS+2];
   assign w_upd_idx         = upd_pc[IDX_BITS+1:2];
   assign w_upd_tag         = upd_pc[31:IDX_BITS+2];
   assign w_pc_plus4        = pc_current + 32'd4;
   assign w_upd_pc_plus4    = upd_pc + 32'd4;
   assign w_unused_low_bits = {pc_current[1:0], upd_pc[1:0]};

   // Zero-latency lookup; sees pre-update contents when indices collide
   always_comb begin
      w_hit       = 1'b0;
      pred_taken  = 1'b0;
      pred_target = w_pc_plus4;
      if (r_valid[w_idx] && (r_tag[w_idx] == w_tag)) begin
         w_hit = 1'b1;
      end else begin
         w_hit = 1'b0;
      end
      if (w_hit && r_ctr[w_idx][1]) begin
         pred_taken  = 1'b1;
         pred_target = r_target[w_idx];
      end else begin
         pred_taken  = 1'b0;
         pred_target = w_pc_plus4;
      end
   end

   // Mispredict detection and redirect priority over the prediction
   always_comb begin
      w_mispredict = 1'b0;
      next_pc      = pred_target;
      if (upd_valid && ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)))) begin
         w_mispredict = 1'b1;
      end else begin
         w_mispredict = 1'b0;
      end
      if (w_mispredict) begin
         next_pc = upd_taken ? upd_target : w_upd_pc_plus4;
      end else begin
         next_pc = pred_target;
      end
   end

   assign flush = w_mispredict;

   // Update-side hit test and saturating counter step
   always_comb begin
      w_upd_hit  = 1'b0;
      w_upd_ctr  = r_ctr[w_upd_idx];
      w_ctr_next = w_upd_ctr;
      if (r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag)) begin
         w_upd_hit = 1'b1;
      end else begin
         w_upd_hit = 1'b0;
      end
      case (upd_taken)
         1'b1:    w_ctr_next = (w_upd_ctr == 2'b11) ? 2'b11 : (w_upd_ctr + 2'd1);
         1'b0:    w_ctr_next = (w_upd_ctr == 2'b00) ? 2'b00 : (w_upd_ctr - 2'd1);
         default: w_ctr_next = w_upd_ctr;
      endcase
   end

   // BTB storage: reset dominates any same-cycle update
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= 32'd0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (upd_valid) begin
         if (w_upd_hit) begin
            r_ctr[w_upd_idx] <= w_ctr_next;
            if (upd_taken) begin
               r_target[w_upd_idx] <= upd_target;
            end
         end else if (upd_taken) begin
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target;
            r_ctr[w_upd_idx]    <= 2'b10;
         end
      end
   end

`ifdef PRED_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;

   // Event counters, wrapping naturally at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_branches    <= 32'd0;
         r_stat_mispredicts <= 32'd0;
      end else begin
         if (upd_valid) begin
            r_stat_branches <= r_stat_branches + 32'd1;
         end
         if (w_mispredict) begin
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         end
      end
   end

   assign stat_branches    = r_stat_branches;
   assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed self-checking bench for next_pc_predictor; stats checks compile in with PRED_STATS_EN.
`timescale 1ns/1ps
module tb_next_pc_predictor;

   logic        clk;
   logic        reset;
   logic [31:0] pc_current;
   logic [31:0] next_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        flush;
`ifdef PRED_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   int n_compared   = 0;
   int n_mismatched = 0;

   next_pc_predictor dut (
      .clk             (clk),
      .reset           (reset),
      .pc_current      (pc_current),
      .next_pc         (next_pc),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .flush           (flush)
`ifdef PRED_STATS_EN
      ,
      .stat_branches   (stat_branches),
      .stat_mispredicts(stat_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs are then changed 2ns after the edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
      upd_valid       = v;
      upd_pc          = pc;
      upd_taken       = tk;
      upd_target      = tgt;
      upd_pred_taken  = ptk;
      upd_pred_target = ptgt;
   endtask

   task automatic idle();
      set_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      pc_current = 32'h0000_0040;
      idle();
      tick();
      tick();
      reset = 1'b0;
      #1;
      // 1: post-reset lookup
      check_val("rst_next_pc", next_pc, 32'h0000_0044);
      check_val("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      check_val("rst_pred_target", pred_target, 32'h0000_0044);
      check_val("rst_flush", {31'd0, flush}, 32'd0);

      // 2: allocation through a mispredicted taken branch
      set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
      #1;
      check_val("alloc_flush", {31'd0, flush}, 32'd1);
      check_val("alloc_next_pc", next_pc, 32'h0000_0100);
      tick();
      idle();
      #1;
      check_val("alloc_hit_taken", {31'd0, pred_taken}, 32'd1);
      check_val("alloc_hit_next", next_pc, 32'h0000_0100);

      // 3: hysteresis; same-cycle lookup still sees ctr=10
      set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
      #1;
      check_val("nt_flush", {31'd0, flush}, 32'd1);
      check_val("nt_next_pc", next_pc, 32'h0000_0044);
      check_val("nt_same_cycle_taken", {31'd0, pred_taken}, 32'd1);
      tick();
      idle();
      #1;
      check_val("ctr01_taken", {31'd0, pred_taken}, 32'd0);
      check_val("ctr01_next", next_pc, 32'h0000_0044);
      set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
      tick();
      idle();
      #1;
      check_val("ctr10_taken", {31'd0, pred_taken}, 32'd1);
      set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      #1;
      check_val("correct_no_flush", {31'd0, flush}, 32'd0);
      check_val("correct_next_pc", next_pc, 32'h0000_0100);
      tick();
      set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      tick();
      // one not-taken from a saturated 11 leaves 10, still taken
      set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
      tick();
      idle();
      #1;
      check_val("sat_then_nt_taken", {31'd0, pred_taken}, 32'd1);
      set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
      tick();
      idle();
      #1;
      check_val("down_to_01_taken", {31'd0, pred_taken}, 32'd0);

      // 4: aliasing at index 0 (0x40 tag 1, 0x80 tag 2)
      pc_current = 32'h0000_0080;
      #1;
      check_val("alias_taken", {31'd0, pred_taken}, 32'd0);
      check_val("alias_next", next_pc, 32'h0000_0084);
      set_upd(1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
      tick();
      idle();
      #1;
      check_val("replace_hit_taken", {31'd0, pred_taken}, 32'd1);
      check_val("replace_hit_next", next_pc, 32'h0000_0200);
      pc_current = 32'h0000_0040;
      #1;
      check_val("evicted_taken", {31'd0, pred_taken}, 32'd0);
      check_val("evicted_next", next_pc, 32'h0000_0044);
      // miss + not taken must not write
      set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
      #1;
      check_val("miss_nt_flush", {31'd0, flush}, 32'd0);
      tick();
      idle();
      pc_current = 32'h0000_0080;
      #1;
      check_val("miss_nt_nowrite", next_pc, 32'h0000_0200);

      // 5: wrap and target mismatch
      pc_current = 32'hFFFF_FFFC;
      #1;
      check_val("wrap_next", next_pc, 32'h0000_0000);
      set_upd(1'b1, 32'h40, 1'b1, 32'h104, 1'b1, 32'h100);
      #1;
      check_val("tgt_mis_flush", {31'd0, flush}, 32'd1);
      check_val("tgt_mis_next", next_pc, 32'h0000_0104);
      set_upd(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h100);
      #1;
      check_val("upd_wrap_next", next_pc, 32'h0000_0000);
      tick();
      idle();

      // 6: reset wins over a same-cycle update
      reset = 1'b1;
      set_upd(1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
      tick();
      reset = 1'b0;
      idle();
      pc_current = 32'h0000_0300;
      #1;
      check_val("rst_upd_taken", {31'd0, pred_taken}, 32'd0);
      check_val("rst_upd_next", next_pc, 32'h0000_0304);
      pc_current = 32'h0000_0080;
      #1;
      check_val("rst_cleared_next", next_pc, 32'h0000_0084);

`ifdef PRED_STATS_EN
      check_val("stat_br_zero", stat_branches, 32'd0);
      check_val("stat_mp_zero", stat_mispredicts, 32'd0);
      set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
      tick();
      set_upd(1'b1, 32'h48, 1'b0, 32'h0, 1'b0, 32'h4C);
      tick();
      set_upd(1'b1, 32'h50, 1'b1, 32'h600, 1'b0, 32'h54);
      tick();
      idle();
      tick();
      check_val("stat_br_three", stat_branches, 32'd3);
      check_val("stat_mp_one", stat_mispredicts, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check_val("stat_br_reset", stat_branches, 32'd0);
      check_val("stat_mp_reset", stat_mispredicts, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/next_pc_predictor.md
Name: next_pc_predictor

Overview:
Fetch-side next-PC generator that sits directly upstream of the PC register and drives its input every cycle. It holds a direct-mapped branch target buffer (BTB) of 2-bit saturating counters, indexed by the current PC. It predicts pc+4 or a cached branch target. It accepts branch resolutions from the ID stage, detects mispredicts, and redirects fetch and raises a flush on a mispredict.

Parameters:
IDX_BITS, 4, log2 of BTB entries (16 entries); index = pc[IDX_BITS+1:2]
TAG_BITS, 30-IDX_BITS, derived (localparam); tag = pc[31:IDX_BITS+2]

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
pc_current  input  32  current PC (PC register output)
next_pc  output  32  value for the PC register input
pred_taken  output  1  lookup hit with counter MSB set; carried down pipeline
pred_target  output  32  predicted next PC; carried down pipeline
upd_valid  input  1  a branch resolved in ID this cycle
upd_pc  input  32  PC of the resolved branch
upd_taken  input  1  actual outcome
upd_target  input  32  actual taken target
upd_pred_taken  input  1  pred_taken recorded when that branch was fetched
upd_pred_target  input  32  pred_target recorded when that branch was fetched
flush  output  1  mispredict; kill the IF/ID instruction
stat_branches  output  32  present only with PRED_STATS_EN
stat_mispredicts  output  32  present only with PRED_STATS_EN

Behaviour:
- BTB entry storage: valid (1b), tag (TAG_BITS), target (32b), ctr (2b). Storage is registers, not RAM.
- Reset, synchronous and checked before all other logic: every valid bit is cleared and every ctr is set to 2'b01. Outputs after reset: pred_taken=0, pred_target=pc_current+4, next_pc=pc_current+4, flush=0.
- Lookup is combinational with zero latency:
  - hit = valid[idx] and tag match.
  - pred_taken = hit and ctr[1].
  - pred_target = pred_taken ? target[idx] : pc_current+4.
  - pc+4 wraps modulo 2^32, so 0xFFFFFFFC+4 = 0x00000000.
- Mispredict (combinational): mispredict = upd_valid and (upd_taken != upd_pred_taken, or upd_taken and upd_target != upd_pred_target). flush = mispredict.
- next_pc selection:
  - If mispredict: next_pc = upd_taken ? upd_target : upd_pc+4.
  - Otherwise: next_pc = pred_target. Redirect has priority over the prediction.
- Update, applied at the clock edge when upd_valid=1, using upd_pc for index and tag:
  - Hit: ctr saturating increment if taken (max 2'b11), decrement if not taken (min 2'b00). If taken, target is overwritten with upd_target.
  - Miss and taken: allocate or replace the entry: valid=1, new tag, target=upd_target, ctr=2'b10.
  - Miss and not taken: no write.
- Updates are independent of PC hold, since the stall logic deasserts upd_valid during stalls. The block itself has no hold input; the PC register ignores next_pc while held.
- Same-cycle lookup and update on the same index: the lookup sees the pre-update contents. The new value is visible on the next cycle.
- reset together with upd_valid: reset wins and no update occurs.
- Low PC bits [1:0] are ignored for index and tag.

Optional Feature:
- Macro: PRED_STATS_EN.
- When defined:
  - stat_branches increments on every cycle with upd_valid=1.
  - stat_mispredicts increments on every cycle with mispredict=1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, are cleared by reset, and are registered (the value reflects events through the previous edge).
- When undefined: both ports and counters are absent, and the rest of the behaviour is identical.

Test Plan:
1. Reset, then pc_current=0x00000040 with upd_valid=0 -> next_pc=0x00000044, pred_taken=0, flush=0.
2. Allocation on a mispredicted branch:
   - Stimulus: upd_valid=1, upd_pc=0x40, upd_taken=1, upd_target=0x100, upd_pred_taken=0.
   - Same cycle: flush=1, next_pc=0x100.
   - Next cycle with pc_current=0x40: pred_taken=1 (ctr=10), next_pc=0x100.
3. Counter hysteresis:
   - After test 2, resolve 0x40 not-taken once: flush=1, next_pc=0x44, and the following lookup gives pred_taken=0 (ctr=01).
   - Resolve taken twice more: pred_taken=1 (ctr=11). Saturation at 11 holds after a third taken.
4. Aliasing:
   - Allocate 0x40 (taken to 0x100), then look up 0x80 (same index, different tag) -> pred_taken=0, next_pc=0x84.
   - Resolve 0x80 taken to 0x200 -> the entry is replaced, and the lookup of 0x40 now misses.
5. Wrap and target mismatch:
   - pc_current=0xFFFFFFFC with a BTB miss -> next_pc=0x00000000.
   - upd_pred_taken=1, upd_pred_target=0x100, upd_taken=1, upd_target=0x104 -> flush=1, next_pc=0x104.
6. Reset and stats:
   - Assert reset in the same cycle as an update -> that entry is still invalid afterwards.
   - With PRED_STATS_EN: three resolutions with one mispredict -> stat_branches=3, stat_mispredicts=1.
   - Reset -> both counters return to 0.
